// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, iteration count and small decode helpers.
package mult_div_unit_pkg;

    // Operation encodings on the op input
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CALC  = 2'b01;
    localparam logic [1:0] ST_FIXUP = 2'b10;

    // One iteration per operand bit
    localparam int ITER_COUNT = 32;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Magnitude of a value, treated as two's complement only when en is set.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit.
// Multiply: radix-2 shift-add on operand magnitudes, 64-bit product in {acc,mq}.
// Divide: restoring shift-subtract, remainder in acc, quotient in mq.
// A single 33-bit adder/subtractor serves both paths; signs are applied in
// FIXUP. Handshake: start is sampled only while idle (busy=0); the result on
// hi/lo is valid from the cycle where done pulses until the next completion.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [1:0]  state;
    logic [5:0]  count;
    logic        div_q;     // operation in flight is a divide
    logic        neg_lo;    // negate product (multiply) or quotient (divide)
    logic        neg_hi;    // negate remainder (signed divide only)
    logic [31:0] acc;       // product high half / partial remainder
    logic [31:0] mq;        // multiplier -> product low half / dividend -> quotient
    logic [31:0] opnd_b;    // multiplicand or divisor magnitude

    logic        in_signed;
    logic        in_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        in_neg;

    logic [32:0] add_x;
    logic [32:0] add_y;
    logic [33:0] add_res;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy = (state != ST_IDLE);

    // Decode the incoming request into operand magnitudes and result sign
    always_comb begin
        in_signed = op_is_signed(op);
        in_div    = op_is_div(op);
        mag_a     = abs32(a, in_signed);
        mag_b     = abs32(b, in_signed);
        in_neg    = in_signed & (a[31] ^ b[31]);
    end

    // Shared 33-bit adder: add for multiply, subtract (borrow = ~bit33) for divide
    always_comb begin
        add_x   = div_q ? {acc, mq[31]} : {1'b0, acc};
        add_y   = {1'b0, opnd_b};
        add_res = {1'b0, add_x} + {1'b0, add_y ^ {33{div_q}}} + {33'd0, div_q};
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod_fix = neg_lo ? (64'd0 - {acc, mq}) : {acc, mq};
        quo_fix  = neg_lo ? (32'd0 - mq) : mq;
        rem_fix  = neg_hi ? (32'd0 - acc) : acc;
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= 6'd0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            div_q  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            acc    <= 32'd0;
            mq     <= 32'd0;
            opnd_b <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        div_q <= in_div;
                        count <= 6'd0;
                        if (in_div && (b == 32'd0)) begin
                            // Divide by zero: FIXUP passes acc/mq straight through
                            acc    <= a;
                            mq     <= 32'hFFFF_FFFF;
                            opnd_b <= 32'd0;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= ST_FIXUP;
                        end else if (in_div) begin
                            acc    <= 32'd0;
                            mq     <= mag_a;
                            opnd_b <= mag_b;
                            neg_lo <= in_neg;
                            neg_hi <= in_signed & a[31];
                            state  <= ST_CALC;
                        end else begin
                            acc    <= 32'd0;
                            mq     <= mag_b;
                            opnd_b <= mag_a;
                            neg_lo <= in_neg;
                            neg_hi <= 1'b0;
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    count <= count + 6'd1;
                    if (div_q) begin
                        if (add_res[33]) begin
                            acc <= add_res[31:0];
                            mq  <= {mq[30:0], 1'b1};
                        end else begin
                            acc <= {acc[30:0], mq[31]};
                            mq  <= {mq[30:0], 1'b0};
                        end
                    end else begin
                        if (mq[0]) begin
                            acc <= add_res[32:1];
                            mq  <= {add_res[0], mq[31:1]};
                        end else begin
                            acc <= {1'b0, acc[31:1]};
                            mq  <= {acc[0], mq[31:1]};
                        end
                    end
                    if (count == 6'(ITER_COUNT - 1)) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    if (div_q) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model,
// per-cycle compare of busy/done/hi/lo, and literal result checks.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit chk_en   = 0;

    logic [63:0] exp_q[$];   // expected {hi,lo} per accepted operation
    int          due_q[$];   // edge after which done must be high
    logic [63:0] held = 64'd0;

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model from the arithmetic definition of each operation
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            OP_MULT:  return 64'(sx * sy);
            OP_MULTU: return ux * uy;
            OP_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q  = sx / sy;
                r  = sx % sy;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                qv = ux / uy;
                rv = ux % uy;
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = (due_q.size() > 0) && (edge_n < due_q[0]);
            exp_done = (due_q.size() > 0) && (edge_n == due_q[0]);
            check1("busy", {63'd0, busy}, {63'd0, exp_busy});
            check1("done", {63'd0, done}, {63'd0, exp_done});
            if ((due_q.size() > 0) && (edge_n >= due_q[0])) begin
                held = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            check1("hilo", {hi, lo}, held);
        end
    end

    // Drivers: all tasks start and end at negedge+2
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
        exp_q.push_back(model(o, x, y));
        if (op_is_div(o) && (y == 32'd0)) due_q.push_back(edge_n + 1);
        else due_q.push_back(edge_n + ITER_COUNT + 1);
        step();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((due_q.size() > 0) && (n < 100)) begin
            step();
            n++;
        end
        if (due_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: got no completion expected done within 100 cycles");
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] lit);
        drive_start(o, x, y);
        wait_done();
        check1(name, {hi, lo}, lit);
    endtask

    initial begin
        int target;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        check1("reset_state", {30'd0, busy, done, hi, lo}, 66'd0);
        rst_n = 1'b1;
        step();

        // Directed arithmetic vectors with hand-computed results
        run_lit("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_lit("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run_lit("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_lit("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_lit("div_negb",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run_lit("divu_small", OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E);
        run_lit("divu_zero",  OP_DIVU,  32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF);
        run_lit("div_zero",   OP_DIV,   32'h8765_4321, 32'd0,         64'h8765_4321_FFFF_FFFF);
        run_lit("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_lit("divu_big",   OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF);

        // start pulsed during CALC is ignored
        drive_start(OP_MULTU, 32'd1000, 32'd3000);
        repeat (5) step();
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd55;
        b     = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        step();
        wait_done();
        check1("ignored_start", {hi, lo}, 64'd3000000);

        // start held in the done cycle is accepted
        drive_start(OP_DIVU, 32'd1000, 32'd33);
        target = due_q[0];
        while (edge_n < target) step();
        check1("b2b_done", {63'd0, done}, 64'd1);
        drive_start(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check1("b2b_busy", {63'd0, busy}, 64'd1);
        check1("b2b_first", {hi, lo}, 64'h0000_000A_0000_001E);
        wait_done();
        check1("b2b_second", {hi, lo}, 64'd1);

        // Reset at iteration 10 of a MULT aborts without a done pulse
        drive_start(OP_MULT, 32'd12345, 32'hFFFF_FF00);
        repeat (9) step();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        due_q.delete();
        held  = 64'd0;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        step();
        rst_n = 1'b1;
        check1("abort_state", {30'd0, busy, done, hi, lo}, 66'd0);
        repeat (40) step();
        check1("abort_idle", {30'd0, busy, done, hi, lo}, 66'd0);
        run_lit("after_reset", OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
